store_align_unit: RTL and testbench

Parametrised store datapath that follows the combinational byte/half/word store aligner.
- Queues store requests from the LSU.
- Aligns data and byte strobes to a DATA_W-wide memory bus.
- Splits stores that cross a bus word into two beats.
- Drives a valid/ready write channel to data memory.
- Adds double-word support (DATA_W=64) and a misalignment policy.

---
 rtl/store_pkg.sv | 30 +++
 rtl/store_req_fifo.sv | 55 +++++
 rtl/store_align_unit.sv | 188 ++++++++++++++++++
 tb/tb_store_align_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared types for the store aligner: request size codes, FSM states and the
// strobe helper used to place a store's bytes onto the memory lanes.
package store_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_D = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND0 = 2'd1,
      SEND1 = 2'd2
   } state_e;

   // Strobe over two consecutive bus words (lanes 0..15); callers truncate to 2*B.
   function automatic logic [15:0] strb_calc(input size_e size, input logic [2:0] off);
      logic [15:0] w_len;
      case (size)
         SZ_B:    w_len = 16'h0001;
         SZ_H:    w_len = 16'h0003;
         SZ_W:    w_len = 16'h000F;
         default: w_len = 16'h00FF;
      endcase
      return w_len << off;
   endfunction

endpackage

// File: rtl/store_req_fifo.sv
// Small show-ahead FIFO holding packed store requests; the head entry is
// visible combinationally so the aligner can decide in the same cycle.
module store_req_fifo #(
   parameter int WIDTH = 66,
   parameter int DEPTH = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   // A full queue refuses a write even when the head leaves in the same cycle.
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_data  = r_mem[r_rptr];

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= i_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end

endmodule

// File: rtl/store_align_unit.sv
// Queued store datapath: positions LSU store data/strobes on the memory bus,
// splitting bus-word-crossing stores into two beats on a valid/ready channel.
module store_align_unit
   import store_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 32,
   parameter int DEPTH          = 2,
   parameter int ALLOW_MISALIGN = 1
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_req_valid,
   output logic                o_req_ready,
   input  logic [ADDR_W-1:0]   i_req_addr,
   input  logic [DATA_W-1:0]   i_req_data,
   input  logic [1:0]          i_req_size,
   output logic                o_mem_valid,
   input  logic                i_mem_ready,
   output logic [ADDR_W-1:0]   o_mem_addr,
   output logic [DATA_W-1:0]   o_mem_wdata,
   output logic [DATA_W/8-1:0] o_mem_strb,
   output logic                o_misalign_err,
   output logic                o_busy
);

   localparam int B      = DATA_W / 8;
   localparam int LOG_B  = $clog2(B);
   localparam int FIFO_W = ADDR_W + DATA_W + 2;

   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic [FIFO_W-1:0] w_fifo_in;
   logic [FIFO_W-1:0] w_head;

   logic [ADDR_W-1:0]   w_h_addr;
   logic [DATA_W-1:0]   w_h_data;
   size_e               w_h_size;
   logic [LOG_B-1:0]    w_off;
   logic                w_mis;
   logic                w_illegal;
   logic [B-1:0]        w_len_strb;
   logic [DATA_W-1:0]   w_byte_mask;
   logic [2*B-1:0]      w_strb_wide;
   logic [2*DATA_W-1:0] w_wide;
   logic                w_split;
   logic [ADDR_W-1:0]   w_base0;
   logic [ADDR_W-1:0]   w_base1;

   state_e            r_state;
   logic              r_mem_valid;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [B-1:0]      r_mem_strb;
   logic [ADDR_W-1:0] r_b1_addr;
   logic [DATA_W-1:0] r_b1_wdata;
   logic [B-1:0]      r_b1_strb;
   logic              r_split;
   logic              r_err;

   // Ready is masked by reset so every output reads 0 while reset is held.
   assign o_req_ready = i_rst_n & ~w_full;
   assign w_push      = i_req_valid & o_req_ready;
   assign w_fifo_in   = {i_req_addr, i_req_data, i_req_size};
   assign w_pop       = (r_state == IDLE) & ~w_empty;

   store_req_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push),
      .i_data  (w_fifo_in),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_h_addr = w_head[FIFO_W-1 -: ADDR_W];
   assign w_h_data = w_head[DATA_W+1:2];
   assign w_h_size = size_e'(w_head[1:0]);
   assign w_off    = w_h_addr[LOG_B-1:0];

   always_comb begin
      w_mis = 1'b0;
      case (w_h_size)
         SZ_B:    w_mis = 1'b0;
         SZ_H:    w_mis = w_h_addr[0];
         SZ_W:    w_mis = |w_h_addr[1:0];
         default: w_mis = |w_h_addr[2:0];
      endcase
   end

   assign w_illegal = ((w_h_size == SZ_D) && (DATA_W == 32)) ||
                      ((ALLOW_MISALIGN == 0) && w_mis);

   assign w_len_strb = B'(strb_calc(w_h_size, 3'd0));

   generate
      for (genvar gi = 0; gi < B; gi++) begin : g_mask
         assign w_byte_mask[8*gi +: 8] = {8{w_len_strb[gi]}};
      end
   endgenerate

   // Data is positioned across two bus words; the upper word is beat1.
   assign w_strb_wide = (2*B)'(strb_calc(w_h_size, 3'(w_off)));
   assign w_wide      = {{DATA_W{1'b0}}, w_h_data & w_byte_mask} << {w_off, 3'b000};
   assign w_split     = |w_strb_wide[2*B-1:B];
   assign w_base0     = {w_h_addr[ADDR_W-1:LOG_B], {LOG_B{1'b0}}};
   assign w_base1     = w_base0 + ADDR_W'(B);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_mem_valid <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_strb  <= '0;
         r_b1_addr   <= '0;
         r_b1_wdata  <= '0;
         r_b1_strb   <= '0;
         r_split     <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  if (w_illegal) begin
                     r_err <= 1'b1;
                  end else begin
                     r_mem_valid <= 1'b1;
                     r_mem_addr  <= w_base0;
                     r_mem_wdata <= w_wide[DATA_W-1:0];
                     r_mem_strb  <= w_strb_wide[B-1:0];
                     r_b1_addr   <= w_base1;
                     r_b1_wdata  <= w_wide[2*DATA_W-1:DATA_W];
                     r_b1_strb   <= w_strb_wide[2*B-1:B];
                     r_split     <= w_split;
                     r_state     <= SEND0;
                  end
               end
            end
            SEND0: begin
               if (i_mem_ready) begin
                  if (r_split) begin
                     r_mem_addr  <= r_b1_addr;
                     r_mem_wdata <= r_b1_wdata;
                     r_mem_strb  <= r_b1_strb;
                     r_state     <= SEND1;
                  end else begin
                     r_mem_valid <= 1'b0;
                     r_mem_addr  <= '0;
                     r_mem_wdata <= '0;
                     r_mem_strb  <= '0;
                     r_state     <= IDLE;
                  end
               end
            end
            SEND1: begin
               if (i_mem_ready) begin
                  r_mem_valid <= 1'b0;
                  r_mem_addr  <= '0;
                  r_mem_wdata <= '0;
                  r_mem_strb  <= '0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_mem_valid <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign o_mem_valid    = r_mem_valid;
   assign o_mem_addr     = r_mem_addr;
   assign o_mem_wdata    = r_mem_wdata;
   assign o_mem_strb     = r_mem_strb;
   assign o_misalign_err = r_err;
   assign o_busy         = ~w_empty | (r_state != IDLE);

endmodule

// File: tb/tb_store_align_unit.sv
// Three aligner instances (32-bit misalign-ok, 32-bit strict, 64-bit) driven
// one at a time and compared against a byte-level model of the store rules.
module tb_store_align_unit;

   typedef struct {
      bit          err;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic [7:0]  strb;
   } item_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  req_valid;
   logic [31:0] req_addr;
   logic [63:0] req_data;
   logic [1:0]  req_size;
   logic        mem_ready;
   int          rdy_mode;

   wire  [2:0]  req_ready;
   wire  [2:0]  mem_valid;
   wire  [2:0]  mis_err;
   wire  [2:0]  busy;
   wire  [31:0] mem_addr  [3];
   wire  [63:0] mem_wdata [3];
   wire  [7:0]  mem_strb  [3];

   int    n_tests = 0;
   int    n_fail  = 0;
   item_t exp_q[$];

   bit          hold   [3];
   logic [31:0] h_addr [3];
   logic [63:0] h_wdata[3];
   logic [7:0]  h_strb [3];

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int DW = (gi == 2) ? 64 : 32;
      localparam int MA = (gi == 1) ? 0 : 1;
      logic [DW-1:0]   w_wdata;
      logic [DW/8-1:0] w_strb;
      store_align_unit #(
         .DATA_W         (DW),
         .ADDR_W         (32),
         .DEPTH          (2),
         .ALLOW_MISALIGN (MA)
      ) u_dut (
         .i_clk          (clk),
         .i_rst_n        (rst_n),
         .i_req_valid    (req_valid[gi]),
         .o_req_ready    (req_ready[gi]),
         .i_req_addr     (req_addr),
         .i_req_data     (req_data[DW-1:0]),
         .i_req_size     (req_size),
         .o_mem_valid    (mem_valid[gi]),
         .i_mem_ready    (mem_ready),
         .o_mem_addr     (mem_addr[gi]),
         .o_mem_wdata    (w_wdata),
         .o_mem_strb     (w_strb),
         .o_misalign_err (mis_err[gi]),
         .o_busy         (busy[gi])
      );
      assign mem_wdata[gi] = 64'(w_wdata);
      assign mem_strb[gi]  = 8'(w_strb);
   end

   function automatic int cfg_dw(int d);
      return (d == 2) ? 64 : 32;
   endfunction

   function automatic int cfg_ma(int d);
      return (d == 1) ? 0 : 1;
   endfunction

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Each byte i lands at address addr+i; its bus word decides the beat.
   task automatic model(int dw, int ma, logic [31:0] addr, logic [63:0] data, logic [1:0] size);
      item_t       it0;
      item_t       it1;
      bit          two;
      int          b;
      int          n;
      int          lane;
      logic [31:0] msk;
      logic [31:0] base0;
      logic [31:0] ab;
      b   = dw / 8;
      n   = 1 << size;
      msk = ~(32'(b - 1));
      it0 = '{err: 1'b0, addr: '0, wdata: '0, strb: '0};
      it1 = it0;
      two = 1'b0;
      if ((size == 2'b11 && dw == 32) || (ma == 0 && (addr & 32'(n - 1)) != 0)) begin
         it0.err = 1'b1;
         exp_q.push_back(it0);
         return;
      end
      base0    = addr & msk;
      it0.addr = base0;
      it1.addr = base0 + 32'(b);
      for (int i = 0; i < n; i++) begin
         ab   = addr + 32'(i);
         lane = int'(ab & 32'(b - 1));
         if ((ab & msk) == base0) begin
            it0.wdata[8*lane +: 8] = data[8*i +: 8];
            it0.strb[lane]         = 1'b1;
         end else begin
            it1.wdata[8*lane +: 8] = data[8*i +: 8];
            it1.strb[lane]         = 1'b1;
            two = 1'b1;
         end
      end
      exp_q.push_back(it0);
      if (two) exp_q.push_back(it1);
   endtask

   task automatic take_obs(bit is_err, logic [31:0] a, logic [63:0] w, logic [7:0] s);
      item_t e;
      $display("[TB] %s addr=%08h wdata=%016h strb=%02h", is_err ? "err " : "beat", a, w, s);
      check("exp_pending", 64'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("beat_kind", is_err, e.err);
         if (!e.err && !is_err) begin
            check("beat_addr", a, e.addr);
            check("beat_wdata", w, e.wdata);
            check("beat_strb", s, e.strb);
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
               hold[d] = 1'b0;
            end else begin
               if (hold[d]) begin
                  check("hold_valid", mem_valid[d], 1);
                  check("hold_addr", mem_addr[d], h_addr[d]);
                  check("hold_wdata", mem_wdata[d], h_wdata[d]);
                  check("hold_strb", mem_strb[d], h_strb[d]);
               end
               if (mis_err[d]) take_obs(1'b1, 32'h0, 64'h0, 8'h0);
               if (mem_valid[d] && mem_ready) take_obs(1'b0, mem_addr[d], mem_wdata[d], mem_strb[d]);
               hold[d]    = mem_valid[d] && !mem_ready;
               h_addr[d]  = mem_addr[d];
               h_wdata[d] = mem_wdata[d];
               h_strb[d]  = mem_strb[d];
            end
         end
      end
   end

   initial begin
      mem_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       mem_ready = 1'b0;
            1:       mem_ready = 1'b1;
            default: mem_ready = ($urandom_range(0, 9) < 7);
         endcase
      end
   end

   task automatic cyc(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(int d, logic [31:0] a, logic [63:0] dat, logic [1:0] sz);
      bit acc;
      int k;
      req_addr  = a;
      req_data  = dat;
      req_size  = sz;
      req_valid = 3'b000;
      req_valid[d] = 1'b1;
      acc = 1'b0;
      k   = 0;
      while (!acc && k < 100) begin
         @(negedge clk);
         acc = req_ready[d];
         @(posedge clk);
         #1;
         k++;
      end
      req_valid = 3'b000;
      check("push_accept", acc, 1);
      if (acc) model(cfg_dw(d), cfg_ma(d), a, dat, sz);
   endtask

   task automatic drain(int d);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || busy[d]) && k < 300) begin
         cyc(1);
         k++;
      end
      check("drain_empty", exp_q.size(), 0);
      check("drain_idle", busy[d], 0);
   endtask

   task automatic random_phase(int d, int n);
      logic [31:0] a;
      logic [1:0]  sz;
      rdy_mode = 2;
      for (int t = 0; t < n; t++) begin
         a  = $urandom;
         sz = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) a[31:5] = '1;
         if ($urandom_range(0, 1) == 1) a = a & ~(32'((1 << sz) - 1));
         push(d, a, {$urandom, $urandom}, sz);
         cyc($urandom_range(0, 2));
      end
      drain(d);
   endtask

   initial begin
      int k;
      rst_n     = 1'b0;
      req_valid = 3'b000;
      req_addr  = '0;
      req_data  = '0;
      req_size  = '0;
      rdy_mode  = 0;
      cyc(2);
      for (int d = 0; d < 3; d++) begin
         check("rst_valid", mem_valid[d], 0);
         check("rst_ready", req_ready[d], 0);
         check("rst_addr", mem_addr[d], 0);
         check("rst_wdata", mem_wdata[d], 0);
         check("rst_strb", mem_strb[d], 0);
         check("rst_err", mis_err[d], 0);
         check("rst_busy", busy[d], 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1);

      // 32-bit, misaligned stores allowed
      rdy_mode = 1;
      cyc(2);
      push(0, 32'h1003, 64'hAB, 2'b00);
      @(negedge clk);
      check("lat_t1", mem_valid[0], 0);
      @(negedge clk);
      check("lat_t2", mem_valid[0], 1);
      drain(0);
      push(0, 32'h2002, 64'h11223344, 2'b10);
      drain(0);
      push(0, 32'hFFFF_FFFE, 64'hA1B2C3D4, 2'b10);
      drain(0);
      push(0, 32'h10, 64'h0102030405060708, 2'b11);
      drain(0);

      // back-pressure with queue filling up
      rdy_mode = 0;
      cyc(2);
      push(0, 32'h4000, 64'h01020304, 2'b10);
      push(0, 32'h4011, 64'h55, 2'b00);
      push(0, 32'h4006, 64'h7788, 2'b01);
      @(negedge clk);
      check("full_ready", req_ready[0], 0);
      cyc(3);
      rdy_mode = 1;
      drain(0);

      // reset while the second beat of a split store is pending
      rdy_mode = 0;
      cyc(2);
      push(0, 32'h2002, 64'h11223344, 2'b10);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!mem_valid[0] && k < 20);
      check("split_valid", mem_valid[0], 1);
      rdy_mode = 1;
      @(posedge clk);
      @(negedge clk);
      rdy_mode = 0;
      @(negedge clk);
      check("send1_valid", mem_valid[0], 1);
      check("send1_addr", mem_addr[0], 32'h2004);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_valid", mem_valid[0], 0);
      check("rst_mid_busy", busy[0], 0);
      check("rst_drop_pending", exp_q.size(), 1);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      rdy_mode = 1;
      cyc(10);
      check("post_rst_valid", mem_valid[0], 0);
      check("post_rst_busy", busy[0], 0);

      random_phase(0, 40);

      // 32-bit, strict alignment
      rdy_mode = 1;
      cyc(2);
      push(1, 32'h3001, 64'h5566, 2'b01);
      push(1, 32'h3004, 64'hCAFEBABE, 2'b10);
      drain(1);
      random_phase(1, 40);

      // 64-bit bus
      rdy_mode = 1;
      cyc(2);
      push(2, 32'h8, 64'h0102030405060708, 2'b11);
      drain(2);
      push(2, 32'h1006, 64'hDEADBEEF, 2'b10);
      drain(2);
      push(2, 32'h100D, 64'h1122334455667788, 2'b11);
      drain(2);
      random_phase(2, 40);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
